// File: rtl/instr_mem_if.sv
// Fetch/program bus between the PC/IF logic (master) and the instruction memory (slave).
// Valid/ready: a fetch is accepted on a rising edge only when req_valid=1 and IF_IDWrite=1;
// with IF_IDWrite=0 nothing moves and the master must keep re-presenting its request.
interface instr_mem_if #(
  parameter int ADDR_SIZE  = 32,
  parameter int WORD_WIDTH = 32
);
  logic                  IF_Flush;
  logic                  IF_IDWrite;
  logic                  req_valid;
  logic [ADDR_SIZE-1:0]  read_address;
  logic                  prog_we;
  logic [ADDR_SIZE-1:0]  prog_addr;
  logic [WORD_WIDTH-1:0] prog_data;
  logic [WORD_WIDTH-1:0] instruction;
  logic                  instr_valid;
  logic [ADDR_SIZE-1:0]  instr_addr;
  logic                  fault;

  modport master (
    output IF_Flush, IF_IDWrite, req_valid, read_address, prog_we, prog_addr, prog_data,
    input  instruction, instr_valid, instr_addr, fault
  );

  modport slave (
    input  IF_Flush, IF_IDWrite, req_valid, read_address, prog_we, prog_addr, prog_data,
    output instruction, instr_valid, instr_addr, fault
  );
endinterface

// File: rtl/instr_mem_pipelined.sv
// Byte-addressed big-endian instruction memory with a READ_LATENCY-deep fetch pipeline,
// a program-load write port and alignment/range fault tagging.
module instr_mem_pipelined #(
  parameter int MEM_WIDTH    = 8,
  parameter int WORD_WIDTH   = 32,
  parameter int MEM_DEPTH    = 1024,
  parameter int ADDR_SIZE    = 32,
  parameter int READ_LATENCY = 2
) (
  input logic        clk,
  input logic        rst,
  instr_mem_if.slave bus
);
  localparam int BPW   = WORD_WIDTH / MEM_WIDTH;
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = ADDR_SIZE'(BPW - 1);
  localparam logic [ADDR_SIZE:0]   MAX_BASE   = (ADDR_SIZE + 1)'(MEM_DEPTH - BPW);

  // Range compare is one bit wider than the address so addresses near the top never wrap.
  function automatic logic addr_bad(input logic [ADDR_SIZE-1:0] a);
    return ((a & ALIGN_MASK) != '0) || ({1'b0, a} > MAX_BASE);
  endfunction

  logic [MEM_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  rd_fault;
  logic [IDX_W-1:0]      rd_base;
  logic [WORD_WIDTH-1:0] rd_data;
  logic                  wr_ok;
  logic [IDX_W-1:0]      wr_base;

  logic                  stg_valid_q [READ_LATENCY];
  logic                  stg_valid_d [READ_LATENCY];
  logic                  stg_fault_q [READ_LATENCY];
  logic                  stg_fault_d [READ_LATENCY];
  logic [ADDR_SIZE-1:0]  stg_addr_q  [READ_LATENCY];
  logic [ADDR_SIZE-1:0]  stg_addr_d  [READ_LATENCY];
  logic [WORD_WIDTH-1:0] stg_data_q  [READ_LATENCY];
  logic [WORD_WIDTH-1:0] stg_data_d  [READ_LATENCY];

  // Faulted addresses index location 0 and their data is forced to zero, so no out-of-range access.
  always_comb begin
    rd_fault = addr_bad(bus.read_address);
    rd_base  = rd_fault ? '0 : bus.read_address[IDX_W-1:0];
    rd_data  = '0;
    if (!rd_fault) begin
      for (int b = 0; b < BPW; b++) begin
        rd_data[WORD_WIDTH-1-b*MEM_WIDTH -: MEM_WIDTH] = mem_q[rd_base + IDX_W'(b)];
      end
    end
  end

  always_comb begin
    wr_ok   = bus.prog_we && !addr_bad(bus.prog_addr);
    wr_base = bus.prog_addr[IDX_W-1:0];
  end

  // The array is outside reset; the nonblocking write makes a same-edge fetch see old data.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int b = 0; b < BPW; b++) begin
        mem_q[wr_base + IDX_W'(b)] <= bus.prog_data[WORD_WIDTH-1-b*MEM_WIDTH -: MEM_WIDTH];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < READ_LATENCY; k++) begin
      stg_valid_d[k] = stg_valid_q[k];
      stg_fault_d[k] = stg_fault_q[k];
      stg_addr_d[k]  = stg_addr_q[k];
      stg_data_d[k]  = stg_data_q[k];
    end
    if (bus.IF_Flush) begin
      // Addresses are left alone so instr_addr keeps reporting the last fetch.
      for (int k = 0; k < READ_LATENCY; k++) begin
        stg_valid_d[k] = 1'b0;
        stg_fault_d[k] = 1'b0;
        stg_data_d[k]  = '0;
      end
    end else if (bus.IF_IDWrite) begin
      stg_valid_d[0] = bus.req_valid;
      stg_fault_d[0] = bus.req_valid && rd_fault;
      stg_addr_d[0]  = bus.read_address;
      stg_data_d[0]  = bus.req_valid ? rd_data : '0;
      for (int k = 1; k < READ_LATENCY; k++) begin
        stg_valid_d[k] = stg_valid_q[k-1];
        stg_fault_d[k] = stg_fault_q[k-1];
        stg_addr_d[k]  = stg_addr_q[k-1];
        stg_data_d[k]  = stg_data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        stg_valid_q[k] <= 1'b0;
        stg_fault_q[k] <= 1'b0;
        stg_addr_q[k]  <= '0;
        stg_data_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        stg_valid_q[k] <= stg_valid_d[k];
        stg_fault_q[k] <= stg_fault_d[k];
        stg_addr_q[k]  <= stg_addr_d[k];
        stg_data_q[k]  <= stg_data_d[k];
      end
    end
  end

  assign bus.instruction = stg_data_q[READ_LATENCY-1];
  assign bus.instr_valid = stg_valid_q[READ_LATENCY-1];
  assign bus.instr_addr  = stg_addr_q[READ_LATENCY-1];
  assign bus.fault       = stg_fault_q[READ_LATENCY-1];
endmodule

// File: tb/tb_instr_mem_pipelined.sv
// Directed bench for instr_mem_pipelined (READ_LATENCY=2, MEM_DEPTH=1024): latency, stall,
// flush, faults, read/write collision and mid-stream reset.
module tb_instr_mem_pipelined;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  instr_mem_if #(.ADDR_SIZE(32), .WORD_WIDTH(32)) bus ();

  instr_mem_pipelined #(
    .MEM_WIDTH(8), .WORD_WIDTH(32), .MEM_DEPTH(1024), .ADDR_SIZE(32), .READ_LATENCY(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a);
    bus.req_valid    = 1'b1;
    bus.read_address = a;
  endtask

  task automatic idle();
    bus.req_valid    = 1'b0;
    bus.read_address = 32'h0;
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = d;
    tick();
    bus.prog_we   = 1'b0;
  endtask

  // checkers
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] i,
                         input logic [31:0] a, input logic f);
    chk({tag, ".valid"}, 32'(bus.instr_valid), 32'(v));
    chk({tag, ".instr"}, bus.instruction, i);
    chk({tag, ".addr"},  bus.instr_addr, a);
    chk({tag, ".fault"}, 32'(bus.fault), 32'(f));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst            = 1'b1;
    bus.IF_Flush   = 1'b0;
    bus.IF_IDWrite = 1'b1;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = 32'h0;
    bus.prog_data  = 32'h0;
    idle();
    tick();
    tick();
    chk_out("reset", 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;

    prog(32'h0,   32'h2008_0005);
    prog(32'h4,   32'h3C00_0001);
    prog(32'h8,   32'h1111_1111);
    prog(32'hC,   32'hCAFE_F00D);
    prog(32'd1020, 32'hDEAD_BEEF);
    prog(32'd1024, 32'h5555_5555);
    tick();
    tick();

    // latency: two back-to-back fetches
    req(32'h0);
    tick();
    chk("lat.bubble", 32'(bus.instr_valid), 32'h0);
    req(32'h4);
    tick();
    chk_out("lat.w0", 1'b1, 32'h2008_0005, 32'h0, 1'b0);
    idle();
    tick();
    chk_out("lat.w4", 1'b1, 32'h3C00_0001, 32'h4, 1'b0);
    tick();
    chk("lat.drain", 32'(bus.instr_valid), 32'h0);

    // stall for three cycles with a word on the output and one in stage 1
    req(32'h0);
    tick();
    req(32'hC);
    tick();
    bus.IF_IDWrite = 1'b0;
    req(32'h4);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk_out("stall.hold", 1'b1, 32'h2008_0005, 32'h0, 1'b0);
    end
    bus.IF_IDWrite = 1'b1;
    idle();
    tick();
    chk_out("stall.late", 1'b1, 32'hCAFE_F00D, 32'hC, 1'b0);
    tick();
    chk("stall.nodup", 32'(bus.instr_valid), 32'h0);

    // flush with two fetches in flight
    req(32'h4);
    tick();
    req(32'h0);
    tick();
    chk("flush.pre", bus.instruction, 32'h3C00_0001);
    bus.IF_Flush = 1'b1;
    req(32'hC);
    tick();
    chk_out("flush.edge", 1'b0, 32'h0, 32'h4, 1'b0);
    bus.IF_Flush = 1'b0;
    req(32'h8);
    tick();
    chk("flush.killed", 32'(bus.instr_valid), 32'h0);
    idle();
    tick();
    chk_out("flush.next", 1'b1, 32'h1111_1111, 32'h8, 1'b0);
    tick();
    chk("flush.drain", 32'(bus.instr_valid), 32'h0);

    // faults: misaligned, last word, one past end, top of address space
    req(32'h2);
    tick();
    req(32'd1020);
    tick();
    chk_out("fault.mis", 1'b1, 32'h0, 32'h2, 1'b1);
    req(32'd1024);
    tick();
    chk_out("fault.last", 1'b1, 32'hDEAD_BEEF, 32'd1020, 1'b0);
    req(32'hFFFF_FFFC);
    tick();
    chk_out("fault.end", 1'b1, 32'h0, 32'd1024, 1'b1);
    idle();
    tick();
    chk_out("fault.nowrap", 1'b1, 32'h0, 32'hFFFF_FFFC, 1'b1);

    // same-edge write and read of word 8
    bus.prog_we   = 1'b1;
    bus.prog_addr = 32'h8;
    bus.prog_data = 32'hAAAA_AAAA;
    req(32'h8);
    tick();
    bus.prog_we = 1'b0;
    req(32'h8);
    tick();
    chk_out("coll.old", 1'b1, 32'h1111_1111, 32'h8, 1'b0);
    idle();
    tick();
    chk_out("coll.new", 1'b1, 32'hAAAA_AAAA, 32'h8, 1'b0);
    idle();
    prog(32'h9, 32'h5555_5555);
    req(32'h8);
    tick();
    req(32'hC);
    tick();
    chk("misw.w8", bus.instruction, 32'hAAAA_AAAA);
    idle();
    tick();
    chk("misw.wC", bus.instruction, 32'hCAFE_F00D);

    // reset with two fetches in flight
    req(32'h0);
    tick();
    req(32'h4);
    tick();
    chk("rst.pre", bus.instruction, 32'h2008_0005);
    rst = 1'b1;
    req(32'hC);
    tick();
    chk_out("rst.mid", 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    idle();
    tick();
    chk("rst.lost", 32'(bus.instr_valid), 32'h0);
    req(32'h8);
    tick();
    idle();
    tick();
    chk_out("rst.mem", 1'b1, 32'hAAAA_AAAA, 32'h8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_mem_pipelined.md
Name: instr_mem_pipelined

Overview:
Parametrised, byte-addressed, big-endian instruction memory with a configurable read pipeline (READ_LATENCY stages). It includes a program-load write port, per-word valid/address tagging, and alignment/range fault detection. It sits between the PC/IF logic and the IF/ID register and honours the pipeline's IF_Flush and IF_IDWrite (stall) controls. Each in-flight fetch is tracked stage by stage.

Parameters:
- MEM_WIDTH, 8: bits per addressable memory location (byte).
- WORD_WIDTH, 32: instruction width; must be a multiple of MEM_WIDTH. BPW = WORD_WIDTH/MEM_WIDTH must be a power of two.
- MEM_DEPTH, 1024: number of MEM_WIDTH locations; must be a multiple of BPW.
- ADDR_SIZE, 32: address width.
- READ_LATENCY, 2: read pipeline depth, legal range 1..4.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- IF_Flush, in, 1: kills all in-flight fetches and zeroes the output.
- IF_IDWrite, in, 1: 1 = pipeline advances; 0 = stall (hold all stages).
- req_valid, in, 1: fetch request qualifier.
- read_address, in, ADDR_SIZE: byte address of the fetch.
- prog_we, in, 1: program-load write enable.
- prog_addr, in, ADDR_SIZE: byte address of the program word.
- prog_data, in, WORD_WIDTH: program word, big-endian (MSB byte goes to the lowest address).
- instruction, out, WORD_WIDTH: fetched instruction (0 = NOP when invalid or faulted).
- instr_valid, out, 1: instruction/instr_addr/fault are meaningful.
- instr_addr, out, ADDR_SIZE: address that produced the current instruction.
- fault, out, 1: fetch was misaligned or out of range.

Behaviour:
- Reset:
  - instruction=0, instr_valid=0, instr_addr=0, fault=0.
  - All stage valid bits are cleared.
  - Memory array contents are NOT reset.
- Priority per edge: rst > IF_Flush > IF_IDWrite==0 (stall) > normal advance.
- Stage 1 capture:
  - Occurs when IF_IDWrite=1.
  - Captured fields: valid=req_valid, addr=read_address, fault flag, and data.
  - Data = {mem[a], mem[a+1], ..., mem[a+BPW-1]}, concatenated MSB first.
  - If req_valid=0, a bubble (valid=0, data=0) enters the pipeline.
- Advance and output:
  - Stages k→k+1 shift only when IF_IDWrite=1. The final stage drives the outputs.
  - Latency: a request sampled at edge N appears on the outputs after edge N+READ_LATENCY−1, i.e. READ_LATENCY edges including the capture edge, provided there are no stalls.
  - READ_LATENCY=1 is equivalent to a single registered read.
- Stall (IF_IDWrite=0, no flush):
  - Every stage and every output holds its value.
  - req_valid and read_address are ignored, and the request is not queued; the PC logic re-presents it.
  - A stall of any length adds exactly that many cycles to the latency.
- Flush (IF_Flush=1):
  - On that edge, all stage valids are cleared, instruction=0, instr_valid=0, fault=0.
  - instr_addr holds its value.
  - A request presented in the flush cycle is discarded.
  - The next request is accepted on the following edge.
- Fault:
  - Condition: read_address[log2(BPW)-1:0]!=0, or read_address > MEM_DEPTH−BPW (evaluated in ADDR_SIZE+1 bits, so there is no wrap).
  - A faulted request propagates with valid=1, fault=1, data=0.
  - No out-of-bounds array access is made.
- Program write:
  - When prog_we=1 and prog_addr is aligned and in range, the BPW bytes are written big-endian on the edge.
  - Misaligned or out-of-range writes are silently dropped.
  - Writes are independent of stall, flush and reset (but the array is not cleared by reset).
- Same-edge write and read of the same word: stage 1 captures the OLD data (read-before-write). A read on the following edge sees the new data.
- Fetches already in flight are not updated by a later write.
- Reset mid-operation: all in-flight fetches are lost, and valid deasserts on the next edge.

Test Plan:
- Latency: load word 0x20080005 at 0x0 and 0x3C000001 at 0x4 via prog_we. With READ_LATENCY=2, req addr 0 at edge 1 and addr 4 at edge 2 → edge 2 out 0x20080005/valid/addr 0; edge 3 out 0x3C000001/addr 4.
- Stall: with a fetch in flight, hold IF_IDWrite=0 for 3 cycles → outputs are frozen. The word emerges 3 cycles late, exactly once, with no duplicate or lost word.
- Flush: two fetches in flight, IF_Flush=1 for one edge → instruction=0, instr_valid=0. Neither in-flight word ever appears. A request on the next edge is delivered normally.
- Faults: req addr 0x2 → valid=1, fault=1, instruction=0. Req addr 1020 (MEM_DEPTH=1024) → valid, no fault. Req addr 1024 → fault=1. Req addr 0xFFFFFFFC → fault=1 (no wrap).
- Read/write collision: mem[8]=0x11111111; same edge prog_we addr 8 data 0xAAAAAAAA plus req addr 8 → 0x11111111 is returned. Next req addr 8 → 0xAAAAAAAA. prog_we at addr 9 → memory unchanged.
- Reset: assert rst mid-stream with 2 fetches in flight → next edge all outputs are 0 and valid=0. Memory retains 0xAAAAAAAA at 8, verified by a post-reset fetch.
